// File: rtl/ls_lib_pkg.sv
// Shared definitions for the 74LSXX-style logic library: the default channel
// count and a constant ceil(log2) helper for sizing counters.
package ls_lib_pkg;

  localparam int LS_DEFAULT_CHANNELS = 6;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/schmitt_filter_channel.sv
// One Schmitt-trigger channel: accepts a new input level only after FILTER
// consecutive differing samples, and pulses CHG on the edge it commits.
module schmitt_filter_channel
  import ls_lib_pkg::*;
#(
  parameter int FILTER = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic A,
  output logic S,
  output logic CHG
);

  localparam int CW = (clog2(FILTER) < 1) ? 1 : clog2(FILTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [CW-1:0] cnt;

  // A counter at CNT_LAST either commits or clears, so it can never wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      S   <= 1'b0;
      cnt <= '0;
      CHG <= 1'b0;
    end else if (!EN) begin
      CHG <= 1'b0;
    end else if (A == S) begin
      cnt <= '0;
      CHG <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      S   <= A;
      cnt <= '0;
      CHG <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      CHG <= 1'b0;
    end
  end

endmodule

// File: rtl/schmitt_not_gate_bank.sv
// Bank of CHANNELS independent Schmitt-trigger gates; INV_MASK selects per
// channel between inverting (LS14) and buffering (LS07-style) output.
module schmitt_not_gate_bank
  import ls_lib_pkg::*;
#(
  parameter int                    CHANNELS = LS_DEFAULT_CHANNELS,
  parameter int                    FILTER   = 4,
  parameter logic [CHANNELS-1:0]   INV_MASK = '1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [CHANNELS-1:0] A,
  output logic [CHANNELS-1:0] Y,
  output logic [CHANNELS-1:0] CHG
);

  logic [CHANNELS-1:0] s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    schmitt_filter_channel #(
      .FILTER(FILTER)
    ) u_chan (
      .CLK(CLK),
      .RST(RST),
      .EN (EN),
      .A  (A[i]),
      .S  (s[i]),
      .CHG(CHG[i])
    );
  end

  // Polarity is a constant, so Y depends only on registered state.
  assign Y = s ^ INV_MASK;

endmodule

// File: tb/tb_schmitt_not_gate_bank.sv
// Directed bench for schmitt_not_gate_bank: a cycle-by-cycle vector table on
// the default 6-channel/FILTER=4 bank plus a hand sequence on an 8-channel
// FILTER=1 mixed-polarity bank.
module tb_schmitt_not_gate_bank;

  typedef struct {
    logic       rst;
    logic       en;
    logic [5:0] a;
    logic [5:0] exp_y;
    logic [5:0] exp_chg;
    string      tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1;
  logic       en0 = 1'b1;
  logic [5:0] a0 = '0;
  logic [5:0] y0;
  logic [5:0] chg0;

  logic       rst1 = 1'b1;
  logic       en1 = 1'b1;
  logic [7:0] a1 = '0;
  logic [7:0] y1;
  logic [7:0] chg1;

  int checks = 0;
  int passed = 0;

  vec_t vecs[$];

  schmitt_not_gate_bank #(
    .CHANNELS(6),
    .FILTER  (4),
    .INV_MASK(6'b111111)
  ) dut0 (
    .CLK(clk),
    .RST(rst0),
    .EN (en0),
    .A  (a0),
    .Y  (y0),
    .CHG(chg0)
  );

  schmitt_not_gate_bank #(
    .CHANNELS(8),
    .FILTER  (1),
    .INV_MASK(8'h0F)
  ) dut1 (
    .CLK(clk),
    .RST(rst1),
    .EN (en1),
    .A  (a1),
    .Y  (y1),
    .CHG(chg1)
  );

  // clock
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic en, input logic [5:0] a,
                     input logic [5:0] y, input logic [5:0] chg, input string tag,
                     input int reps = 1);
    vec_t v;
    v.rst = rst; v.en = en; v.a = a; v.exp_y = y; v.exp_chg = chg; v.tag = tag;
    for (int r = 0; r < reps; r++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic step0(input vec_t v, input int idx);
    @(negedge clk);
    rst0 = v.rst; en0 = v.en; a0 = v.a;
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].y", v.tag, idx), {2'b00, y0}, {2'b00, v.exp_y});
    check($sformatf("%s[%0d].chg", v.tag, idx), {2'b00, chg0}, {2'b00, v.exp_chg});
  endtask

  task automatic step1(input logic rst, input logic [7:0] a, input logic [7:0] exp_y,
                       input logic [7:0] exp_chg, input string tag);
    @(negedge clk);
    rst1 = rst; a1 = a;
    @(posedge clk);
    #1;
    check({tag, ".y"}, y1, exp_y);
    check({tag, ".chg"}, chg1, exp_chg);
  endtask

  initial begin
    // reset, then all channels commit 4 edges after release
    add(1, 1, 6'h3F, 6'h3F, 6'h00, "rst_hold", 2);
    add(0, 1, 6'h3F, 6'h3F, 6'h00, "rst_rel", 3);
    add(0, 1, 6'h3F, 6'h00, 6'h3F, "rst_commit");
    add(0, 1, 6'h3F, 6'h00, 6'h00, "rst_after");
    add(1, 1, 6'h00, 6'h3F, 6'h00, "rereset");
    // glitch of FILTER-1 rejected, then a full FILTER run accepted
    add(0, 1, 6'h01, 6'h3F, 6'h00, "glitch", 3);
    add(0, 1, 6'h00, 6'h3F, 6'h00, "glitch_end");
    add(0, 1, 6'h01, 6'h3F, 6'h00, "accept", 3);
    add(0, 1, 6'h01, 6'h3E, 6'h01, "accept_commit");
    add(0, 1, 6'h01, 6'h3E, 6'h00, "accept_after");
    // staggered independent channels
    add(0, 1, 6'h03, 6'h3E, 6'h00, "indep", 2);
    add(0, 1, 6'h07, 6'h3E, 6'h00, "indep_b2");
    add(0, 1, 6'h07, 6'h3C, 6'h02, "indep_c1");
    add(0, 1, 6'h07, 6'h3C, 6'h00, "indep_mid");
    add(0, 1, 6'h07, 6'h38, 6'h04, "indep_c2");
    // enable freeze mid-count
    add(0, 1, 6'h0F, 6'h38, 6'h00, "en_pre", 2);
    add(0, 0, 6'h0F, 6'h38, 6'h00, "en_off", 5);
    add(0, 1, 6'h0F, 6'h38, 6'h00, "en_resume");
    add(0, 1, 6'h0F, 6'h30, 6'h08, "en_commit");
    // reset mid-count (with EN low, reset still wins)
    add(0, 1, 6'h1F, 6'h30, 6'h00, "mid_cnt", 3);
    add(1, 0, 6'h1F, 6'h3F, 6'h00, "mid_rst");
    add(0, 1, 6'h1F, 6'h3F, 6'h00, "fresh", 3);
    add(0, 1, 6'h1F, 6'h20, 6'h1F, "fresh_commit");
    add(0, 1, 6'h1F, 6'h20, 6'h00, "fresh_after");

    for (int i = 0; i < vecs.size(); i++) step0(vecs[i], i);

    // FILTER=1, mixed polarity: commit on the same edge
    step1(1'b1, 8'hA5, 8'h0F, 8'h00, "w8_rst");
    step1(1'b0, 8'hA5, 8'hAA, 8'hA5, "w8_a5");
    step1(1'b0, 8'hA5, 8'hAA, 8'h00, "w8_hold");
    step1(1'b0, 8'h5A, 8'h55, 8'hFF, "w8_5a");
    en1 = 1'b0;
    step1(1'b0, 8'h00, 8'h55, 8'h00, "w8_frozen");
    en1 = 1'b1;
    step1(1'b0, 8'h00, 8'h0F, 8'h5A, "w8_clear");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
